vpg_mode_ctrl: RTL and testbench

VPG_MODE_CTRL -- requirements
Module: vpg_mode_ctrl

---
 rtl/vpg_mode_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_vpg_mode_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// vpg_mode_ctrl
//
// Sequences a video mode change. The timing generator is held in reset, the PLL
// is reconfigured for the requested mode, the controller waits for a qualified
// lock and a settle window, and the timing generator is then released in the
// new mode. Requests that arrive while a sequence is in flight are queued
// (latest wins) and run as soon as the current sequence reaches RUN.
//
// Optional feature (compile-time macro VPG_LOCK_TIMEOUT_EN):
//   defined   - a LOCK dwell of LOCK_TIMEOUT cycles sets the sticky lock_err flag
//               and retries the PLL reconfiguration with the same target.
//   undefined - LOCK waits indefinitely and lock_err is constant 0.
//
// Ports
//   clk              in   rising-edge clock for all logic
//   reset_n          in   synchronous active-low reset
//   vpg_mode_change  in   one-cycle pulse, new mode presented on vpg_mode
//   vpg_mode[3:0]    in   requested mode, sampled only with vpg_mode_change
//   pll_busy         in   PLL reconfiguration engine busy
//   pll_locked       in   PLL lock indicator (already synchronous to clk)
//   pll_start        out  one-cycle pulse starting PLL reconfiguration
//   pll_mode[3:0]    out  mode given to the PLL engine, held between sequences
//   timing_mode[3:0] out  mode applied to the timing generator
//   timing_rst_n     out  active-low reset to the timing generator
//   vpg_ready        out  timing generator running in a stable mode
//   lock_err         out  sticky lock-timeout flag
// -----------------------------------------------------------------------------
module vpg_mode_ctrl #(
  parameter int HOLD_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vpg_mode_change,
  input  logic [3:0] vpg_mode,
  input  logic       pll_busy,
  input  logic       pll_locked,
  output logic       pll_start,
  output logic [3:0] pll_mode,
  output logic [3:0] timing_mode,
  output logic       timing_rst_n,
  output logic       vpg_ready,
  output logic       lock_err
);

  // The shared counter serves HOLD, WAIT_BUSY (needs to reach 2) and SETTLE.
  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES)
                         ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                         : ((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2);
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HOLD, ST_RECONF, ST_WAIT_BUSY, ST_LOCK, ST_SETTLE, ST_RUN
  } state_e;

  state_e        state_q,         state_d;
  logic [CW-1:0] cnt_q,           cnt_d;
  logic [3:0]    target_q,        target_d;
  logic [3:0]    pending_q,       pending_d;
  logic          pending_valid_q, pending_valid_d;
  logic          lock_prev_q,     lock_prev_d;
  logic          pll_start_q,     pll_start_d;
  logic [3:0]    pll_mode_q,      pll_mode_d;
  logic [3:0]    timing_mode_q,   timing_mode_d;
  logic          timing_rst_n_q,  timing_rst_n_d;
  logic          vpg_ready_q,     vpg_ready_d;
  logic [CW-1:0] cnt_inc;

`ifdef VPG_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q,   to_cnt_d;
  logic          lock_err_q, lock_err_d;
  logic [TW-1:0] to_cnt_inc;
  assign to_cnt_inc = (to_cnt_q == TW'(LOCK_TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
`endif

  // Counters saturate instead of wrapping.
  assign cnt_inc = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_inc;
    target_d        = target_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    lock_prev_d     = lock_prev_q;
    pll_start_d     = 1'b0;
    pll_mode_d      = pll_mode_q;
    timing_mode_d   = timing_mode_q;
    timing_rst_n_d  = timing_rst_n_q;
    vpg_ready_d     = vpg_ready_q;
`ifdef VPG_LOCK_TIMEOUT_EN
    to_cnt_d        = to_cnt_inc;
    lock_err_d      = lock_err_q;
`endif

    // Requests during an active sequence are queued; the newest overwrites.
    if (vpg_mode_change && (state_q inside {ST_HOLD, ST_RECONF, ST_WAIT_BUSY,
                                           ST_LOCK, ST_SETTLE})) begin
      pending_d       = vpg_mode;
      pending_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (vpg_mode_change) begin
          target_d       = vpg_mode;
          state_d        = ST_HOLD;
          cnt_d          = '0;
          timing_rst_n_d = 1'b0;
          vpg_ready_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) state_d = ST_RECONF;
      end
      ST_RECONF: begin
        if (!pll_busy) begin
          pll_start_d = 1'b1;
          pll_mode_d  = target_q;
          state_d     = ST_WAIT_BUSY;
          cnt_d       = '0;
        end
      end
      ST_WAIT_BUSY: begin
        // The engine may take a cycle or two to raise busy after the start
        // pulse, so a low busy is ignored until two cycles have passed.
        if (!pll_busy && (cnt_q >= CW'(2))) begin
          state_d     = ST_LOCK;
          lock_prev_d = 1'b0;
`ifdef VPG_LOCK_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      ST_LOCK: begin
        lock_prev_d = pll_locked;
        if (pll_locked && lock_prev_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
`ifdef VPG_LOCK_TIMEOUT_EN
        else if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          lock_err_d = 1'b1;
          state_d    = ST_RECONF;
        end
`endif
      end
      ST_SETTLE: begin
        if (!pll_locked) begin
          state_d     = ST_LOCK;
          lock_prev_d = 1'b0;
`ifdef VPG_LOCK_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          timing_mode_d  = target_q;
          timing_rst_n_d = 1'b1;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        // A fresh request beats a queued one (latest wins); a queued request
        // restarts before vpg_ready is ever raised.
        if (vpg_mode_change || pending_valid_q || !pll_locked) begin
          if (vpg_mode_change)      target_d = vpg_mode;
          else if (pending_valid_q) target_d = pending_q;
          pending_valid_d = 1'b0;
          state_d         = ST_HOLD;
          cnt_d           = '0;
          timing_rst_n_d  = 1'b0;
          vpg_ready_d     = 1'b0;
        end else begin
          vpg_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      target_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      lock_prev_q     <= 1'b0;
      pll_start_q     <= 1'b0;
      pll_mode_q      <= '0;
      timing_mode_q   <= '0;
      timing_rst_n_q  <= 1'b0;
      vpg_ready_q     <= 1'b0;
`ifdef VPG_LOCK_TIMEOUT_EN
      to_cnt_q        <= '0;
      lock_err_q      <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      target_q        <= target_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      lock_prev_q     <= lock_prev_d;
      pll_start_q     <= pll_start_d;
      pll_mode_q      <= pll_mode_d;
      timing_mode_q   <= timing_mode_d;
      timing_rst_n_q  <= timing_rst_n_d;
      vpg_ready_q     <= vpg_ready_d;
`ifdef VPG_LOCK_TIMEOUT_EN
      to_cnt_q        <= to_cnt_d;
      lock_err_q      <= lock_err_d;
`endif
    end
  end

  assign pll_start    = pll_start_q;
  assign pll_mode     = pll_mode_q;
  assign timing_mode  = timing_mode_q;
  assign timing_rst_n = timing_rst_n_q;
  assign vpg_ready    = vpg_ready_q;
`ifdef VPG_LOCK_TIMEOUT_EN
  assign lock_err     = lock_err_q;
`else
  // Constant 0 for any legal LOCK_TIMEOUT; the comparison only keeps the
  // parameter referenced in the build without the timeout logic.
  assign lock_err     = (LOCK_TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_vpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vpg_mode_ctrl
//
// Directed-plus-random bench for vpg_mode_ctrl. The bench plays the PLL: it
// answers each pll_start with a busy window and a later lock. Expected event
// times are derived from the sequencing rules with plain arithmetic:
//   start  = request edge + HOLD + 1      (one cycle in RECONF, busy low)
//   rise   = edge after which lock is driven + 2 + SETTLE
//   ready  = rise + 1
// Queued requests are modelled as a list whose last entry wins.
// -----------------------------------------------------------------------------
module tb_vpg_mode_ctrl;

  localparam int H  = 4;
  localparam int S  = 20;
  localparam int LT = 100;
`ifdef VPG_LOCK_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vpg_mode_change = 1'b0;
  logic [3:0] vpg_mode = '0;
  logic       pll_busy = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_start;
  logic [3:0] pll_mode;
  logic [3:0] timing_mode;
  logic       timing_rst_n;
  logic       vpg_ready;
  logic       lock_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;

  logic [3:0] cur_mode;
  logic [3:0] reqs[$];
  logic [3:0] late_modes[3];

  vpg_mode_ctrl #(
    .HOLD_CYCLES  (H),
    .SETTLE_CYCLES(S),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vpg_mode_change(vpg_mode_change),
    .vpg_mode       (vpg_mode),
    .pll_busy       (pll_busy),
    .pll_locked     (pll_locked),
    .pll_start      (pll_start),
    .pll_mode       (pll_mode),
    .timing_mode    (timing_mode),
    .timing_rst_n   (timing_rst_n),
    .vpg_ready      (vpg_ready),
    .lock_err       (lock_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (pll_start === 1'b1) n_start++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle request; a = edge at which the DUT samples it.
  task automatic req(input logic [3:0] m, output int a);
    vpg_mode        = m;
    vpg_mode_change = 1'b1;
    step();
    a               = cyc;
    vpg_mode_change = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (pll_start === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic wait_rise(input int budget, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (timing_rst_n === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  // PLL behaviour after a start pulse: lock drops, busy for b cycles, lock
  // returns ld cycles later. p = edge after which lock is driven high.
  task automatic respond(input int b, input int ld, output int p);
    pll_locked = 1'b0;
    pll_busy   = 1'b1;
    repeat (b) step();
    pll_busy   = 1'b0;
    repeat (ld) step();
    pll_locked = 1'b1;
    p          = cyc;
  endtask

  task automatic finish_seq(input logic [3:0] m, input int b, input int ld, input string tag);
    int p, r;
    respond(b, ld, p);
    wait_rise(4 * S + 50, r);
    check({tag, ".rise_cyc"}, r, p + 2 + S);
    check({tag, ".timing_mode"}, timing_mode, m);
    step();
    check({tag, ".ready"}, vpg_ready, 1);
  endtask

  task automatic run_seq(input logic [3:0] m, input int b, input int ld, input string tag);
    int a, s;
    req(m, a);
    wait_start(H + 20, s);
    check({tag, ".start_cyc"}, s, a + H + 1);
    check({tag, ".pll_mode"}, pll_mode, m);
    finish_seq(m, b, ld, tag);
  endtask

  initial begin
    int a, s, p, p2, r, d, n0;
    logic [3:0] m;
    late_modes = '{4'd2, 4'd5, 4'd7};

    // Reset values.
    repeat (3) step();
    check("rst.pll_start", pll_start, 0);
    check("rst.pll_mode", pll_mode, 0);
    check("rst.timing_mode", timing_mode, 0);
    check("rst.timing_rst_n", timing_rst_n, 0);
    check("rst.vpg_ready", vpg_ready, 0);
    check("rst.lock_err", lock_err, 0);
    reset_n = 1'b1;
    step();

    // Basic sequence to mode 3: busy 5 cycles, lock 10 cycles later.
    n0 = n_start;
    run_seq(4'd3, 5, 10, "basic");
    check("basic.n_start", n_start - n0, 1);
    cur_mode = 4'd3;

    // Random modes and PLL timings; iteration 1 repeats the current mode.
    for (int i = 0; i < 4; i++) begin
      m = (i == 1) ? cur_mode : 4'($urandom_range(1, 15));
      run_seq(m, int'($urandom_range(2, 6)), int'($urandom_range(2, 10)), "rand");
      cur_mode = m;
    end

    // Three requests during SETTLE of mode 1: mode 1 reaches RUN without
    // ready, then only the last request runs.
    n0 = n_start;
    req(4'd1, a);
    wait_start(H + 20, s);
    check("queue.start_cyc", s, a + H + 1);
    check("queue.pll_mode", pll_mode, 1);
    respond(3, 4, p);
    while (cyc < p + 4) step();
    reqs.delete();
    for (int i = 0; i < 3; i++) begin
      req(late_modes[i], a);
      reqs.push_back(late_modes[i]);
      step();
    end
    wait_rise(4 * S + 50, r);
    check("queue.rise_cyc", r, p + 2 + S);
    check("queue.timing_mode", timing_mode, 1);
    step();
    check("queue.ready_low", vpg_ready, 0);
    check("queue.rst_low", timing_rst_n, 0);
    wait_start(H + 20, s);
    check("queue.start2_cyc", s, r + H + 2);
    check("queue.pll_mode2", pll_mode, reqs[$]);
    check("queue.ready_still_low", vpg_ready, 0);
    finish_seq(reqs[$], 4, 5, "queue2");
    check("queue.n_start", n_start - n0, 2);
    cur_mode = reqs[$];

    // Lock glitch in SETTLE restarts the full window.
    m = 4'($urandom_range(1, 15));
    req(m, a);
    wait_start(H + 20, s);
    check("glitch.start_cyc", s, a + H + 1);
    respond(3, 3, p);
    while (cyc < p + 8) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    p2 = cyc;
    wait_rise(4 * S + 50, r);
    check("glitch.rise_cyc", r, p2 + 2 + S);
    check("glitch.timing_mode", timing_mode, m);
    step();
    check("glitch.ready", vpg_ready, 1);
    cur_mode = m;

    // Lock loss in RUN re-runs the sequence with the unchanged mode.
    step();
    pll_locked = 1'b0;
    d = cyc;
    step();
    check("loss.ready_low", vpg_ready, 0);
    check("loss.rst_low", timing_rst_n, 0);
    wait_start(H + 20, s);
    check("loss.start_cyc", s, d + H + 2);
    check("loss.pll_mode", pll_mode, cur_mode);
    finish_seq(cur_mode, 2, 2, "loss");

    // Lock never arrives: timeout retry only when the feature is built in.
    m = 4'($urandom_range(1, 15));
    n0 = n_start;
    req(m, a);
    wait_start(H + 20, s);
    check("tmo.start_cyc", s, a + H + 1);
    pll_locked = 1'b0;
    pll_busy   = 1'b1;
    repeat (5) step();
    pll_busy   = 1'b0;
    while (cyc < s + 5 + LT) step();
    check("tmo.lock_err_before", lock_err, 0);
    step();
    check("tmo.lock_err", lock_err, TO_EN);
    step();
    check("tmo.restart", pll_start, TO_EN);
    check("tmo.pll_mode", pll_mode, m);
    repeat (40) step();
    check("tmo.n_start", n_start - n0, 1 + TO_EN);
    check("tmo.lock_err_sticky", lock_err, TO_EN);

    // Reset pulse clears the sticky flag.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("tmo.lock_err_cleared", lock_err, 0);
    step();

    // Reset during WAIT_BUSY abandons the sequence.
    m = 4'($urandom_range(1, 15));
    req(m, a);
    wait_start(H + 20, s);
    check("wbrst.start_cyc", s, a + H + 1);
    pll_busy = 1'b1;
    step();
    reset_n = 1'b0;
    step();
    check("wbrst.pll_start", pll_start, 0);
    check("wbrst.pll_mode", pll_mode, 0);
    check("wbrst.timing_mode", timing_mode, 0);
    check("wbrst.timing_rst_n", timing_rst_n, 0);
    check("wbrst.vpg_ready", vpg_ready, 0);
    check("wbrst.lock_err", lock_err, 0);
    reset_n    = 1'b1;
    pll_busy   = 1'b0;
    pll_locked = 1'b1;
    n0 = n_start;
    repeat (40) step();
    check("wbrst.no_start", n_start - n0, 0);
    check("wbrst.rst_still_low", timing_rst_n, 0);

    // First request after reset starts from IDLE.
    m = 4'($urandom_range(1, 15));
    run_seq(m, 3, 4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
